// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell and a registered carry, LSB first.
// Latency: done pulses WIDTH edges after the start is accepted; one add per WIDTH+1 cycles.
// Backpressure: none; start is only sampled in IDLE or DONE and dropped while busy.

module bit_serial_adder_ctrl_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module bit_serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic ha0_s, ha0_c, ha1_s, ha1_c;
    logic bit_s, bit_c;

    bit_serial_adder_ctrl_ha u_ha0 (.x(a_sr[0]), .y(b_sr[0]), .s(ha0_s), .c(ha0_c));
    bit_serial_adder_ctrl_ha u_ha1 (.x(ha0_s),   .y(carry),   .s(ha1_s), .c(ha1_c));

    assign bit_s = ha1_s;
    assign bit_c = ha0_c | ha1_c;

    // a_sr doubles as the result register: sum bits enter at the MSB as operand bits leave the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr  <= {bit_s, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    carry <= bit_c;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= {bit_s, a_sr[WIDTH-1:1]};
                        cout  <= bit_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
